// File: rtl/abft_chk_n_if.sv
// Handshake bundle for abft_chk_n: data in, reference checksum in, result out.
interface abft_chk_n_if #(
  parameter int unsigned aBits = 18,
  parameter int unsigned zBits = 20
);
  logic             d_valid;
  logic             d_ready;
  logic [aBits-1:0] d_data;
  logic             c_valid;
  logic             c_ready;
  logic [zBits-1:0] c_data;
  logic             r_valid;
  logic             r_ready;
  logic             r_err;
  logic [zBits-1:0] r_syn;

  // Producer/consumer side driving data, checksum and result acknowledge.
  modport master (
    output d_valid, d_data, c_valid, c_data, r_ready,
    input  d_ready, c_ready, r_valid, r_err, r_syn
  );

  // Checker side.
  modport slave (
    input  d_valid, d_data, c_valid, c_data, r_ready,
    output d_ready, c_ready, r_valid, r_err, r_syn
  );
endinterface

// File: rtl/abft_chk_n.sv
// ABFT checksum checker: accumulates N sign-extended words modulo 2^zBits,
// then compares against a reference checksum and reports the syndrome.
// Optional feature macro: ABFT_CHK_TOL_EN (|syndrome| > TOL flags an error
// instead of any nonzero syndrome).
module abft_chk_n #(
  parameter int unsigned aBits = 18,
  parameter int unsigned zBits = 20,
  parameter int unsigned N     = 8,
  parameter int unsigned TOL   = 0
) (
  input  logic        clk,
  input  logic        rst,
  abft_chk_n_if.slave bus,
  output logic        busy
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {ACC, CHK, RPT} state_t;

  state_t           state_q, state_d;
  logic [zBits-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             r_valid_q, r_valid_d;
  logic             r_err_q, r_err_d;
  logic [zBits-1:0] r_syn_q, r_syn_d;

  logic             d_ready_c;
  logic             c_ready_c;
  logic [zBits-1:0] d_ext_c;
  logic [zBits-1:0] syn_c;
  logic             err_c;

  // Sign-extend the incoming word and form the candidate syndrome.
  assign d_ext_c = zBits'($signed(bus.d_data));
  assign syn_c   = bus.c_data - sum_q;

`ifdef ABFT_CHK_TOL_EN
  localparam logic [zBits-1:0] MOST_NEG = {1'b1, {(zBits-1){1'b0}}};
  logic [zBits-1:0] mag_c;

  // Magnitude of the signed syndrome; the most negative value has no
  // positive twin and is always treated as an error.
  assign mag_c = syn_c[zBits-1] ? (-syn_c) : syn_c;
  assign err_c = (syn_c == MOST_NEG) || (64'(mag_c) > 64'(TOL));
`else
  assign err_c = (syn_c != '0);
`endif

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACC;
      sum_q     <= '0;
      cnt_q     <= '0;
      r_valid_q <= 1'b0;
      r_err_q   <= 1'b0;
      r_syn_q   <= '0;
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      r_valid_q <= r_valid_d;
      r_err_q   <= r_err_d;
      r_syn_q   <= r_syn_d;
    end
  end

  // Next-state, accumulation and ready decode.
  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    r_valid_d = r_valid_q;
    r_err_d   = r_err_q;
    r_syn_d   = r_syn_q;
    d_ready_c = 1'b0;
    c_ready_c = 1'b0;
    case (state_q)
      ACC: begin
        d_ready_c = 1'b1;
        if (bus.d_valid) begin
          sum_d = sum_q + d_ext_c;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = CHK;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      CHK: begin
        c_ready_c = 1'b1;
        if (bus.c_valid) begin
          r_syn_d   = syn_c;
          r_err_d   = err_c;
          r_valid_d = 1'b1;
          state_d   = RPT;
        end
      end
      RPT: begin
        if (bus.r_ready) begin
          r_valid_d = 1'b0;
          sum_d     = '0;
          state_d   = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  assign bus.d_ready = d_ready_c;
  assign bus.c_ready = c_ready_c;
  assign bus.r_valid = r_valid_q;
  assign bus.r_err   = r_err_q;
  assign bus.r_syn   = r_syn_q;
  assign busy        = (state_q != ACC) || (cnt_q != '0);

endmodule

// File: tb/tb_abft_chk_n.sv
// Scoreboard bench for abft_chk_n: directed test-plan blocks plus random blocks
// checked against an integer-arithmetic reference model.
module tb_abft_chk_n;
  localparam int unsigned A = 18;
  localparam int unsigned Z = 20;
  localparam int unsigned NW = 8;
`ifdef ABFT_CHK_TOL_EN
  localparam int unsigned TOLP = 2;
`else
  localparam int unsigned TOLP = 0;
`endif
  localparam longint MOD = 64'sd1 << Z;

  logic clk;
  logic rst;
  logic busy;

  abft_chk_n_if #(.aBits(A), .zBits(Z)) bus ();

  abft_chk_n #(.aBits(A), .zBits(Z), .N(NW), .TOL(TOLP)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         err;
    logic [Z-1:0] syn;
  } exp_t;
  exp_t exp_q[$];

  longint model_sum = 0;
  bit     rand_rr   = 1'b0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: checksum minus the true integer sum, reduced modulo 2^Z.
  function automatic exp_t model(input logic [Z-1:0] c);
    exp_t e;
    longint syn, sv;
    syn = ((longint'(c) - model_sum) % MOD + MOD) % MOD;
    sv  = (syn >= MOD / 2) ? syn - MOD : syn;
    e.syn = Z'(syn);
`ifdef ABFT_CHK_TOL_EN
    e.err = ((sv < 0) ? -sv : sv) > longint'(TOLP);
`else
    e.err = (sv != 0);
`endif
    return e;
  endfunction

  task automatic send_word(input logic [A-1:0] w);
    bit rdy;
    int n = 0;
    bus.d_valid = 1'b1;
    bus.d_data  = w;
    forever begin
      if (rand_rr) begin
        bus.r_ready = 1'($urandom_range(1, 0));
        bus.c_valid = 1'($urandom_range(1, 0));
        bus.c_data  = Z'($urandom);
      end
      @(negedge clk);
      rdy = bus.d_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      n++;
      if (n > 200) begin
        chk("d_timeout", 0, 1);
        break;
      end
    end
    model_sum   = model_sum + longint'($signed(w));
    bus.d_valid = 1'b0;
    bus.c_valid = 1'b0;
  endtask

  task automatic send_chk(input logic [Z-1:0] c);
    bit rdy;
    int n = 0;
    bus.c_valid = 1'b1;
    bus.c_data  = c;
    forever begin
      if (rand_rr) bus.d_valid = 1'($urandom_range(1, 0));
      @(negedge clk);
      rdy = bus.c_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      n++;
      if (n > 200) begin
        chk("c_timeout", 0, 1);
        break;
      end
    end
    exp_q.push_back(model(c));
    model_sum   = 0;
    bus.c_valid = 1'b0;
    bus.d_valid = 1'b0;
    chk("r_valid_latency", longint'(bus.r_valid), 1);
  endtask

  task automatic block_seq(input int base, input logic [Z-1:0] c);
    for (int i = 0; i < int'(NW); i++) send_word(A'(base + i));
    send_chk(c);
  endtask

  task automatic block_const(input logic [A-1:0] w, input logic [Z-1:0] c);
    for (int i = 0; i < int'(NW); i++) send_word(w);
    send_chk(c);
  endtask

  task automatic drain();
    int n = 0;
    bus.r_ready = 1'b1;
    while ((exp_q.size() != 0) && (n < 50)) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", longint'(exp_q.size()), 0);
  endtask

  // Monitor: pops the scoreboard on each result handshake and checks that a
  // stalled result stays stable.
  logic         hold;
  logic         h_err;
  logic [Z-1:0] h_syn;
  initial hold = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold <= 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", longint'(bus.r_valid), 1);
        chk("hold_err", longint'(bus.r_err), longint'(h_err));
        chk("hold_syn", longint'(bus.r_syn), longint'(h_syn));
      end
      if (bus.r_valid && bus.r_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("r_err", longint'(bus.r_err), longint'(e.err));
          chk("r_syn", longint'(bus.r_syn), longint'(e.syn));
        end
      end
      hold  <= bus.r_valid && !bus.r_ready;
      h_err <= bus.r_err;
      h_syn <= bus.r_syn;
    end
  end

  initial begin
    bus.d_valid = 1'b0;
    bus.d_data  = '0;
    bus.c_valid = 1'b0;
    bus.c_data  = '0;
    bus.r_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_d_ready", longint'(bus.d_ready), 1);
    chk("rst_c_ready", longint'(bus.c_ready), 0);
    chk("rst_r_valid", longint'(bus.r_valid), 0);
    chk("rst_busy", longint'(busy), 0);
    @(posedge clk);
    #1;

    // Clean block, mismatches, sign and wrap.
    block_seq(1, Z'(36));
    block_seq(1, Z'(37));
    block_seq(1, Z'(35));
    block_const(A'(18'h3FFFF), Z'(20'hFFFF8));
    block_const(A'(18'h1FFFF), Z'(20'hFFFF8));
    // Tolerance edges: syndromes +2, -2, +3, +1.
    block_seq(1, Z'(38));
    block_seq(1, Z'(34));
    block_seq(1, Z'(39));
    drain();

    // Backpressure: result stalls while both valids are asserted.
    for (int i = 0; i < int'(NW); i++) send_word(A'(i + 1));
    bus.r_ready = 1'b0;
    send_chk(Z'(40));
    bus.d_valid = 1'b1;
    bus.c_valid = 1'b1;
    bus.c_data  = Z'(36);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_d_ready", longint'(bus.d_ready), 0);
      chk("bp_c_ready", longint'(bus.c_ready), 0);
    end
    @(posedge clk);
    #1;
    bus.d_valid = 1'b0;
    bus.c_valid = 1'b0;
    drain();
    block_seq(1, Z'(36));
    drain();

    // Reset in the middle of a block.
    for (int i = 0; i < 4; i++) send_word(A'(i + 1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_sum = 0;
    @(negedge clk);
    chk("mid_rst_busy", longint'(busy), 0);
    chk("mid_rst_r_valid", longint'(bus.r_valid), 0);
    chk("mid_rst_d_ready", longint'(bus.d_ready), 1);
    @(posedge clk);
    #1;
    block_seq(1, Z'(36));
    drain();

    // Random blocks with random backpressure and stray checksum valids.
    rand_rr = 1'b1;
    for (int b = 0; b < 40; b++) begin
      longint s = 0;
      logic [A-1:0] w;
      logic [Z-1:0] c;
      for (int i = 0; i < int'(NW); i++) begin
        w = A'($urandom);
        s = s + longint'($signed(w));
        send_word(w);
      end
      case ($urandom_range(2, 0))
        0:       c = Z'(s);
        1:       c = Z'(s + longint'($urandom_range(6, 0)) - 3);
        default: c = Z'($urandom);
      endcase
      send_chk(c);
    end
    rand_rr = 1'b0;
    drain();
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/abft_chk_n.md
# abft_chk_n

Checksum checker for the ABFT datapath. It consumes a block of `N` signed data words and accumulates them with the same sign-extend-and-wrap arithmetic as the producer-side `acc_n`. It then accepts the reference checksum word, computes the syndrome (checksum − local sum) and reports pass/fail over a valid/ready result port. It sits at the consuming end of a checksum-protected vector, opposite the accumulator that generated the checksum.

## Interface
Parameters:
- `aBits`, 18, data word width (two's complement)
- `zBits`, 20, checksum/sum/syndrome width; `zBits >= aBits`
- `N`, 8, data words per block; `N >= 1`
- `TOL`, 0, unsigned error tolerance; used only with `ABFT_CHK_TOL_EN`

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `d_valid` in 1: data word valid.
- `d_ready` out 1: block accepts a data word.
- `d_data` in aBits: signed data word.
- `c_valid` in 1: checksum valid.
- `c_ready` out 1: block accepts the checksum.
- `c_data` in zBits: reference checksum.
- `r_valid` out 1: result valid.
- `r_ready` in 1: result consumed.
- `r_err` out 1: mismatch flag.
- `r_syn` out zBits: syndrome `c_data − sum`, signed.
- `busy` out 1: block in progress; true when state ≠ ACC or word count ≠ 0.

## Operation
- There is one clock. Reset is synchronous and active-high. The ports are `clk` and `rst`.
- A handshake transfers on any cycle where valid && ready. Valid signals asserted while ready is low are ignored and are not queued.
- The FSM has three states: ACC, CHK and RPT.
- **ACC**
  - `d_ready`=1 and `c_ready`=0.
  - Each accepted word is sign-extended to zBits and added to `sum`, modulo 2^zBits. Any carry beyond zBits is dropped.
  - `cnt` counts accepted words, 0..N−1.
  - On the accept that brings the count to N: the word is still added, `cnt` returns to 0, and the FSM goes to CHK.
- **CHK**
  - `d_ready`=0 and `c_ready`=1.
  - On a checksum accept: `r_syn` ← `c_data − sum` (mod 2^zBits), `r_err` ← error rule (see Configuration), `r_valid` ← 1, and the FSM goes to RPT.
- **RPT**
  - `d_ready`=0 and `c_ready`=0.
  - `r_valid`, `r_err` and `r_syn` are held stable until `r_ready`.
  - On the `r_valid && r_ready` handshake: `r_valid` ← 0, `sum` ← 0, and the FSM goes to ACC.
  - `r_err` and `r_syn` keep their last values until the next CHK accept. They are don't-care while `r_valid`=0.
- `d_ready` and `c_ready` are combinational decodes of state only. They do not depend on the valid inputs.
- Reset values: state=ACC, `sum`=0, `cnt`=0, `r_valid`=0, `r_err`=0, `r_syn`=0. After reset, `d_ready`=1, `c_ready`=0 and `busy`=0.
- Reset mid-block discards the partial sum and any pending result. There is no partial report.
- With `N`=1, every data accept goes straight to CHK.

## Timing
- **Data path:** one word is accepted per cycle in ACC. `sum` is updated on the accepting edge.
- **Checksum to result:** `r_valid`=1 in the cycle after the checksum accept, i.e. 1-cycle latency.
- **Result to next data:** `d_ready`=1 in the cycle after the `r_ready` handshake.
- **Throughput:** the minimum block period is N+2 cycles (N data, 1 checksum, 1 report), with `r_ready` tied high.
- **Simultaneous events:**
  - `d_valid` together with `c_valid` in ACC: only data is accepted.
  - `rst` with any handshake: reset wins and the handshake has no effect.

## Configuration
- `ABFT_CHK_TOL_EN` defined: `r_err` = |`r_syn`| > `TOL`, where `r_syn` is interpreted as signed. The most negative zBits value always flags an error.
- `ABFT_CHK_TOL_EN` undefined: `r_err` = (`r_syn` ≠ 0). `TOL` is ignored.

## Test plan
- **Clean block:** defaults, data 1..8 back-to-back, checksum 36 → `r_valid` one cycle after the checksum accept, `r_err`=0, `r_syn`=0.
- **Mismatch:** same data with checksum 37 → `r_err`=1, `r_syn`=1. With checksum 35 → `r_err`=1, `r_syn`=20'hFFFFF (−1).
- **Sign/wrap:**
  - Eight words of 18'h3FFFF with checksum 20'hFFFF8 → `r_err`=0.
  - Eight words of 18'h1FFFF with checksum 20'hFFFF8 (wrapped) → `r_err`=0.
- **Backpressure:** `r_ready` held low for 5 cycles while `d_valid` and `c_valid` are asserted → `r_valid`, `r_err` and `r_syn` stay stable, `d_ready` and `c_ready` stay 0, and nothing is accepted. After release, the next block of data 1..8 with checksum 36 checks clean.
- **Reset mid-block:** `rst` pulsed after 4 words → next cycle shows reset values (`busy`=0, `r_valid`=0). A following full block of 1..8 with checksum 36 → `r_err`=0.
- **Tolerance:** with `ABFT_CHK_TOL_EN` and `TOL`=2, syndromes +2 and −2 give `r_err`=0 and syndrome +3 gives `r_err`=1. Without the macro, syndrome +1 gives `r_err`=1.
